// File: rtl/gpio_ctrl_input_debounce.sv
// GPIO input conditioning: per-pin synchronizer followed by an optional tick-based debounce filter.
// The filter (prescaler and per-pin counters) is built only when GPIO_CTRL_DEBOUNCE_EN is defined.
module gpio_ctrl_input_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      gpio_pad_in,
    input  logic [31:0]      debounce_enable,
    input  logic [15:0]      debounce_prescale,
    input  logic [CNT_W-1:0] debounce_threshold,
    output logic [31:0]      gpio_in_data
);

    logic [31:0] sync_q [SYNC_STAGES];
    logic [31:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= gpio_pad_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef GPIO_CTRL_DEBOUNCE_EN
    logic [15:0]      pre_cnt;
    logic             tick;
    logic [CNT_W-1:0] cnt_q [32];
    logic [CNT_W-1:0] cnt_d [32];
    logic [31:0]      data_d;

    // >= compare lets a lowered prescale take effect without waiting for wrap-around
    assign tick = (pre_cnt >= debounce_prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pre_cnt <= '0;
        else        pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
    end

    always_comb begin
        data_d = gpio_in_data;
        for (int i = 0; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!debounce_enable[i]) begin
                data_d[i] = sync[i];
                cnt_d[i]  = '0;
            end else if (sync[i] == gpio_in_data[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] >= debounce_threshold) begin
                    data_d[i] = sync[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_in_data <= '0;
            for (int i = 0; i < 32; i++) cnt_q[i] <= '0;
        end else begin
            gpio_in_data <= data_d;
            for (int i = 0; i < 32; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`else
    // Filter configuration is meaningless without the filter; fold it into a sink net.
    wire unused_cfg = ^{debounce_enable, debounce_prescale, debounce_threshold};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gpio_in_data <= '0;
        else        gpio_in_data <= sync;
    end
`endif

endmodule

// File: tb/tb_gpio_ctrl_input_debounce.sv
// Randomized bench for gpio_ctrl_input_debounce against a rule-level reference model.
// Model follows GPIO_CTRL_DEBOUNCE_EN the same way the design does.
module tb_gpio_ctrl_input_debounce;

    localparam int SYNC  = 2;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic [31:0]      gpio_pad_in;
    logic [31:0]      debounce_enable;
    logic [15:0]      debounce_prescale;
    logic [CNT_W-1:0] debounce_threshold;
    logic [31:0]      gpio_in_data;

    gpio_ctrl_input_debounce #(.SYNC_STAGES(SYNC), .CNT_W(CNT_W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .gpio_pad_in        (gpio_pad_in),
        .debounce_enable    (debounce_enable),
        .debounce_prescale  (debounce_prescale),
        .debounce_threshold (debounce_threshold),
        .gpio_in_data       (gpio_in_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the pad seen SYNC clocks ago, a free-running tick,
    // and per pin the number of consecutive mismatching ticks seen so far.
    logic [31:0] m_hist [SYNC];
    logic [31:0] m_out;
    int          m_run [32];
    int          m_pres;

    task automatic model_reset();
        for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
        m_out  = '0;
        m_pres = 0;
        for (int i = 0; i < 32; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        logic [31:0] s;
        logic        tk;
        if (!rst_n) begin
            model_reset();
            return;
        end
        s = m_hist[SYNC-1];
`ifdef GPIO_CTRL_DEBOUNCE_EN
        tk = (m_pres >= int'(debounce_prescale));
        m_pres = tk ? 0 : m_pres + 1;
        for (int i = 0; i < 32; i++) begin
            if (!debounce_enable[i] || s[i] == m_out[i]) begin
                if (!debounce_enable[i]) m_out[i] = s[i];
                m_run[i] = 0;
            end else if (tk) begin
                m_run[i] = m_run[i] + 1;
                if (m_run[i] > int'(debounce_threshold)) begin
                    m_out[i] = s[i];
                    m_run[i] = 0;
                end
            end
        end
`else
        tk = 1'b0;
        m_out = s;
`endif
        for (int k = SYNC-1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = gpio_pad_in;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model", gpio_in_data, m_out);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_async", gpio_in_data, 32'h0);
        model_reset();
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    int          n;
    logic        seen;
    logic [31:0] m;

    initial begin
        rst_n = 1'b0;
        gpio_pad_in = '0;
        debounce_enable = '0;
        debounce_prescale = '0;
        debounce_threshold = '0;
        model_reset();
        @(negedge clk);
        chk("reset_out", gpio_in_data, 32'h0);
        cyc();
        rst_n = 1'b1;
        repeat (4) cyc();

        // Bypass latency
        gpio_pad_in = 32'h1;
        cyc(); cyc();
        chk("byp_lat2", {31'b0, gpio_in_data[0]}, 32'h0);
        cyc();
        chk("byp_lat3", {31'b0, gpio_in_data[0]}, 32'h1);

        // Debounced rise on pin 5
        gpio_pad_in = '0;
        debounce_enable = 32'h20;
        debounce_prescale = 16'd3;
        debounce_threshold = 4'd2;
        repeat (6) cyc();
        gpio_pad_in = 32'h20;
        n = 0;
        while (gpio_in_data[5] == 1'b0 && n < 40) begin
            cyc();
            n++;
        end
`ifdef GPIO_CTRL_DEBOUNCE_EN
        chk("db_rise_window", {31'b0, (n >= 11 && n <= 14)}, 32'h1);
`else
        chk("db_rise_cyc", n, 3);
`endif

        // Glitch rejection
        gpio_pad_in = '0;
        repeat (20) cyc();
        chk("glitch_pre", {31'b0, gpio_in_data[5]}, 32'h0);
        gpio_pad_in = 32'h20;
        seen = 1'b0;
        repeat (6) begin cyc(); seen |= gpio_in_data[5]; end
        gpio_pad_in = '0;
        repeat (20) begin cyc(); seen |= gpio_in_data[5]; end
`ifdef GPIO_CTRL_DEBOUNCE_EN
        chk("glitch_reject", {31'b0, seen}, 32'h0);
`else
        chk("glitch_pass", {31'b0, seen}, 32'h1);
`endif

        // Fastest filter: one cycle after sync
        debounce_prescale = 16'd0;
        debounce_threshold = 4'd0;
        repeat (3) cyc();
        gpio_pad_in = 32'h20;
        n = 0;
        while (gpio_in_data[5] == 1'b0 && n < 20) begin
            cyc();
            n++;
        end
        chk("fast_lat", n, 3);

        // Enable dropped mid-count
        gpio_pad_in = '0;
        debounce_prescale = 16'd3;
        debounce_threshold = 4'd3;
        repeat (30) cyc();
        gpio_pad_in = 32'h20;
        repeat (6) cyc();
        debounce_enable = '0;
        cyc();
        chk("en_drop", {31'b0, gpio_in_data[5]}, 32'h1);

        // Reset during active count
        gpio_pad_in = '0;
        debounce_enable = '1;
        repeat (10) cyc();
        gpio_pad_in = 32'hFFFF_FFFF;
        repeat (5) cyc();
        do_reset();
        repeat (10) cyc();
`ifdef GPIO_CTRL_DEBOUNCE_EN
        chk("refilter", gpio_in_data, 32'h0);
`else
        chk("refilter", gpio_in_data, 32'hFFFF_FFFF);
`endif
        repeat (10) cyc();

        // Randomized segments
        for (int seg = 0; seg < 10; seg++) begin
            debounce_enable = $urandom;
            debounce_prescale = 16'($urandom_range(0, 3));
            debounce_threshold = CNT_W'($urandom_range(0, 3));
            if (seg == 6) do_reset();
            for (int c = 0; c < 150; c++) begin
                m = $urandom & $urandom & $urandom & $urandom;
                gpio_pad_in = gpio_pad_in ^ m;
                if ($urandom_range(0, 15) == 0)
                    debounce_enable[$urandom_range(0, 31)] ^= 1'b1;
                if ($urandom_range(0, 63) == 0)
                    debounce_prescale = 16'($urandom_range(0, 3));
                cyc();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_ctrl_input_debounce.md
GPIO_CTRL_INPUT_DEBOUNCE -- requirements
Module: gpio_ctrl_input_debounce

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2, number of synchronizer flops per pin (legal 2..4).
REQ-002 SHALL provide parameter CNT_W, default 4, width of each per-pin debounce counter.
REQ-003 SHALL have port clk  input  1  single block clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port gpio_pad_in  input  32  raw asynchronous pad levels.
REQ-006 SHALL have port debounce_enable  input  32  per-pin filter enable.
REQ-007 SHALL have port debounce_prescale  input  16  sample-tick divider.
REQ-008 SHALL have port debounce_threshold  input  CNT_W  extra stable ticks required.
REQ-009 SHALL have port gpio_in_data  output  32  filtered level, feeds edge detector.

Function
REQ-010 SHALL pass each pad bit through SYNC_STAGES flops; sync[i] is the last stage.
REQ-011 SHALL run one shared 16-bit prescale counter incrementing every cycle; tick asserted for one cycle when count >= debounce_prescale, count then returns to 0.
REQ-012 SHALL give a tick every cycle when debounce_prescale == 0; a tick every P+1 cycles for prescale P.
REQ-013 SHALL, for pin with debounce_enable[i]==0, register gpio_in_data[i] <= sync[i] every cycle and hold counter[i] at 0; pad-to-output latency SYNC_STAGES+1 cycles.
REQ-014 SHALL, for enabled pin with sync[i]==gpio_in_data[i], clear counter[i] to 0 and hold output.
REQ-015 SHALL, for enabled pin with sync[i]!=gpio_in_data[i] and no tick, hold counter[i] and output.
REQ-016 SHALL, for enabled pin with mismatch on tick: if counter[i] >= debounce_threshold, load gpio_in_data[i] <= sync[i] and clear counter[i]; else counter[i] increments.
REQ-017 SHALL therefore accept a new level after threshold+1 consecutive mismatching ticks; threshold 0 accepts on first tick.
REQ-018 SHALL discard accumulated count when the mismatch ends before acceptance (glitch rejection).
REQ-019 SHALL use >= compare so lowering threshold or prescale mid-count never needs wrap-around.
REQ-020 SHALL, on debounce_enable[i] 1->0, clear counter[i] and follow sync[i] from the next cycle; on 0->1 start with counter[i]=0.
REQ-021 SHALL keep pins fully independent; simultaneous transitions on many pins filtered in parallel.

Reset
REQ-022 SHALL asynchronously clear synchronizer flops, prescale counter, all counters and gpio_in_data to 0 on rst_n low.
REQ-023 SHALL resume from the reset state on the first clock after rst_n deasserts; reset mid-filtering discards partial counts.
REQ-024 SHALL reset gpio_in_data to 0 to match the edge detector's previous-value reset, so no spurious interrupt follows reset with pads low.

Configuration
REQ-025 SHALL compile the debounce filter (prescaler, counters, REQ-014..REQ-020) only when GPIO_CTRL_DEBOUNCE_EN is defined.
REQ-026 SHALL, without GPIO_CTRL_DEBOUNCE_EN, drive gpio_in_data as registered sync output (REQ-013 behaviour for all pins) and ignore debounce_enable, debounce_prescale, debounce_threshold.

Verification
REQ-027 Bypass: enable=0, pad[0] 0->1 -> gpio_in_data[0]=1 exactly SYNC_STAGES+1=3 cycles later.
REQ-028 Debounce: enable[5]=1, prescale=3, threshold=2, pad[5] held 1 -> output rises after 3 mismatching ticks (~12 cycles + sync latency), not before.
REQ-029 Glitch: same config, pad[5] high for 6 cycles then low -> gpio_in_data[5] stays 0, counter back to 0.
REQ-030 Edge cases: prescale=0, threshold=0 -> output follows pad one cycle after sync; mid-count enable 1->0 -> output follows sync next cycle.
REQ-031 Reset: assert rst_n low during active count with pads=32'hFFFF_FFFF -> gpio_in_data=0 immediately; after release, refilter from zero counts.
REQ-032 Config: build without GPIO_CTRL_DEBOUNCE_EN, enable=all ones, threshold=15 -> output still tracks pad with 3-cycle latency.
